// File: rtl/ft245_responder_if.sv
// ft245_responder_if
// FT245 async FIFO bus between an FPGA-side master and the device-side
// responder. The master modport belongs to the FPGA logic that drives the
// strobes. The slave modport belongs to the device model that drives the flags
// and the read data.
//   rxf_n  : 0 = byte available for the master to read
//   rd_n   : master read strobe, active low
//   d_out  : read data towards the master
//   d_oe   : 1 = d_out valid and driven
//   txe_n  : 0 = master may write a byte
//   wr_n   : master write strobe, byte latched on its falling edge
//   d_in   : write data from the master
interface ft245_responder_if;
  logic       rxf_n;
  logic       rd_n;
  logic [7:0] d_out;
  logic       d_oe;
  logic       txe_n;
  logic       wr_n;
  logic [7:0] d_in;

  modport master (
    input  rxf_n, txe_n, d_out, d_oe,
    output rd_n, wr_n, d_in
  );

  modport slave (
    output rxf_n, txe_n, d_out, d_oe,
    input  rd_n, wr_n, d_in
  );
endinterface

// File: rtl/ft245_responder.sv
// ft245_responder
// Device-side stand-in for an FTDI FT245 chip. It lets an FPGA-side FT245
// master be looped back and self-tested on chip. Bytes from the PC side
// (host_tx_*) queue in rx_fifo and are handed to the master on rd_n strobes.
// Bytes written by the master on wr_n strobes queue in tx_fifo and drain to
// the PC side (host_rx_*).
// Ports:
//   i_clock_in       system clock, rising edge
//   i_reset_n        asynchronous active-low reset
//   ft               FT245 bus (slave modport)
//   i_host_tx_data   PC->FPGA byte
//   i_host_tx_valid  i_host_tx_data valid
//   o_host_tx_ready  rx_fifo not full
//   o_host_rx_data   FPGA->PC byte (tx_fifo head)
//   o_host_rx_valid  tx_fifo not empty
//   i_host_rx_ready  PC side consumes o_host_rx_data
//   o_proto_err      sticky: a strobe arrived while its flag was inactive
//
// RX FSM (device -> master)
//   state | meaning
//   IDLE  | rxf_n follows rx_fifo empty; waiting for rd_n low
//   DRIVE | read accepted; counting RD_DELAY before driving d_out
//   HOLD  | d_oe=1, d_out stable until rd_n returns high
//   PRE   | byte popped; rxf_n held high for TURN cycles
// TX FSM (master -> device)
//   state | meaning
//   IDLE  | txe_n follows tx_fifo full; waiting for wr_n falling edge
//   WAIT  | byte captured; waiting for wr_n to return high
//   PRE   | txe_n held high for TURN cycles
module ft245_responder #(
  parameter int DEPTH_LOG2 = 4,
  parameter int RD_DELAY   = 1,
  parameter int TURN       = 2
) (
  input  logic                     i_clock_in,
  input  logic                     i_reset_n,
  ft245_responder_if.slave         ft,
  input  logic [7:0]               i_host_tx_data,
  input  logic                     i_host_tx_valid,
  output logic                     o_host_tx_ready,
  output logic [7:0]               o_host_rx_data,
  output logic                     o_host_rx_valid,
  input  logic                     i_host_rx_ready,
  output logic                     o_proto_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam logic [3:0] RD_LOAD   = (RD_DELAY == 0) ? 4'd0 : 4'(RD_DELAY - 1);
  localparam logic [3:0] TURN_LOAD = 4'(TURN - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_DRIVE, RX_HOLD, RX_PRE} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_WAIT, TX_PRE} tx_state_t;

  // strobe history for edge detection
  logic r_rd_q, r_wr_q;
  logic w_rd_rise, w_wr_fall;

  // rx_fifo (PC -> master)
  logic [7:0]            r_rx_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_rx_wptr, r_rx_rptr;
  logic [CW-1:0]         r_rx_cnt;
  logic [CW-1:0]         w_rx_cnt_nxt;
  logic                  r_rx_empty, r_rx_full, r_host_tx_ready;
  logic                  w_rx_push, w_rx_pop;
  logic [7:0]            w_rx_head;

  // tx_fifo (master -> PC)
  logic [7:0]            r_tx_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_tx_wptr, r_tx_rptr;
  logic [CW-1:0]         r_tx_cnt;
  logic [CW-1:0]         w_tx_cnt_nxt;
  logic                  r_tx_empty, r_tx_full;
  logic                  w_tx_push, w_tx_pop;

  // FSM registers and next-state
  rx_state_t  r_rx_state, w_rx_state_nxt;
  tx_state_t  r_tx_state, w_tx_state_nxt;
  logic [3:0] r_rx_tmr, w_rx_tmr_nxt;
  logic [3:0] r_tx_tmr, w_tx_tmr_nxt;
  logic       r_rxf_n, w_rxf_n_nxt;
  logic       r_txe_n, w_txe_n_nxt;
  logic       r_d_oe, w_d_oe_nxt;
  logic [7:0] r_d_out, w_d_out_nxt;
  logic       r_proto_err;
  logic       w_rx_err, w_tx_err;

  assign w_rd_rise = ft.rd_n & ~r_rd_q;
  assign w_wr_fall = r_wr_q & ~ft.wr_n;

  // ---------------- FIFOs ----------------
  assign w_rx_push    = i_host_tx_valid & r_host_tx_ready;
  assign w_rx_head    = r_rx_mem[r_rx_rptr];
  assign w_rx_cnt_nxt = r_rx_cnt + CW'(w_rx_push) - CW'(w_rx_pop);

  assign w_tx_pop     = ~r_tx_empty & i_host_rx_ready;
  assign w_tx_cnt_nxt = r_tx_cnt + CW'(w_tx_push) - CW'(w_tx_pop);

  // storage needs no reset: pointers and counts define what is valid
  always_ff @(posedge i_clock_in) begin
    if (w_rx_push) r_rx_mem[r_rx_wptr] <= i_host_tx_data;
    if (w_tx_push) r_tx_mem[r_tx_wptr] <= ft.d_in;
  end

  always_ff @(posedge i_clock_in or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_rx_wptr       <= '0;
      r_rx_rptr       <= '0;
      r_rx_cnt        <= '0;
      r_rx_empty      <= 1'b1;
      r_rx_full       <= 1'b0;
      r_host_tx_ready <= 1'b0;
      r_tx_wptr       <= '0;
      r_tx_rptr       <= '0;
      r_tx_cnt        <= '0;
      r_tx_empty      <= 1'b1;
      r_tx_full       <= 1'b0;
    end else begin
      if (w_rx_push) r_rx_wptr <= r_rx_wptr + 1'b1;
      if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + 1'b1;
      r_rx_cnt        <= w_rx_cnt_nxt;
      r_rx_empty      <= (w_rx_cnt_nxt == '0);
      r_rx_full       <= (w_rx_cnt_nxt == CW'(DEPTH));
      r_host_tx_ready <= (w_rx_cnt_nxt != CW'(DEPTH));
      if (w_tx_push) r_tx_wptr <= r_tx_wptr + 1'b1;
      if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + 1'b1;
      r_tx_cnt        <= w_tx_cnt_nxt;
      r_tx_empty      <= (w_tx_cnt_nxt == '0);
      r_tx_full       <= (w_tx_cnt_nxt == CW'(DEPTH));
    end
  end

  // ---------------- FSM registers ----------------
  always_ff @(posedge i_clock_in or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_rd_q      <= 1'b1;
      r_wr_q      <= 1'b1;
      r_rx_state  <= RX_IDLE;
      r_tx_state  <= TX_IDLE;
      r_rx_tmr    <= '0;
      r_tx_tmr    <= '0;
      r_rxf_n     <= 1'b1;
      r_txe_n     <= 1'b1;
      r_d_oe      <= 1'b0;
      r_d_out     <= '0;
      r_proto_err <= 1'b0;
    end else begin
      r_rd_q      <= ft.rd_n;
      r_wr_q      <= ft.wr_n;
      r_rx_state  <= w_rx_state_nxt;
      r_tx_state  <= w_tx_state_nxt;
      r_rx_tmr    <= w_rx_tmr_nxt;
      r_tx_tmr    <= w_tx_tmr_nxt;
      r_rxf_n     <= w_rxf_n_nxt;
      r_txe_n     <= w_txe_n_nxt;
      r_d_oe      <= w_d_oe_nxt;
      r_d_out     <= w_d_out_nxt;
      r_proto_err <= r_proto_err | w_rx_err | w_tx_err;
    end
  end

  // ---------------- RX FSM ----------------
  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_rx_tmr_nxt   = r_rx_tmr;
    w_rxf_n_nxt    = r_rxf_n;
    w_d_oe_nxt     = r_d_oe;
    w_d_out_nxt    = r_d_out;
    w_rx_pop       = 1'b0;
    w_rx_err       = 1'b0;
    unique case (r_rx_state)
      RX_IDLE: begin
        w_rxf_n_nxt = r_rx_empty;
        if (!ft.rd_n) begin
          if (r_rxf_n) begin
            w_rx_err = 1'b1;
          end else if (RD_DELAY == 0) begin
            w_d_oe_nxt     = 1'b1;
            w_d_out_nxt    = w_rx_head;
            w_rx_state_nxt = RX_HOLD;
          end else begin
            w_rx_tmr_nxt   = RD_LOAD;
            w_rx_state_nxt = RX_DRIVE;
          end
        end
      end
      RX_DRIVE: begin
        // an aborted read still consumes the byte
        if (w_rd_rise) begin
          w_rx_pop       = 1'b1;
          w_rxf_n_nxt    = 1'b1;
          w_rx_tmr_nxt   = TURN_LOAD;
          w_rx_state_nxt = RX_PRE;
        end else if (r_rx_tmr == '0) begin
          w_d_oe_nxt     = 1'b1;
          w_d_out_nxt    = w_rx_head;
          w_rx_state_nxt = RX_HOLD;
        end else begin
          w_rx_tmr_nxt = r_rx_tmr - 1'b1;
        end
      end
      RX_HOLD: begin
        if (w_rd_rise) begin
          w_rx_pop       = 1'b1;
          w_d_oe_nxt     = 1'b0;
          w_rxf_n_nxt    = 1'b1;
          w_rx_tmr_nxt   = TURN_LOAD;
          w_rx_state_nxt = RX_PRE;
        end
      end
      RX_PRE: begin
        if (!ft.rd_n) w_rx_err = 1'b1;
        // rxf_n is reloaded on the last precharge edge so it stays high exactly TURN cycles
        if (r_rx_tmr == '0) begin
          w_rxf_n_nxt    = r_rx_empty;
          w_rx_state_nxt = RX_IDLE;
        end else begin
          w_rx_tmr_nxt = r_rx_tmr - 1'b1;
        end
      end
      default: w_rx_state_nxt = RX_IDLE;
    endcase
  end

  // ---------------- TX FSM ----------------
  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_tmr_nxt   = r_tx_tmr;
    w_txe_n_nxt    = r_txe_n;
    w_tx_push      = 1'b0;
    // a falling edge while txe_n is high is dropped in every state
    w_tx_err       = w_wr_fall & r_txe_n;
    unique case (r_tx_state)
      TX_IDLE: begin
        w_txe_n_nxt = r_tx_full;
        if (w_wr_fall && !r_txe_n) begin
          w_tx_push      = 1'b1;
          w_txe_n_nxt    = 1'b1;
          w_tx_state_nxt = TX_WAIT;
        end
      end
      TX_WAIT: begin
        if (ft.wr_n) begin
          w_tx_tmr_nxt   = TURN_LOAD;
          w_tx_state_nxt = TX_PRE;
        end
      end
      TX_PRE: begin
        if (r_tx_tmr == '0) begin
          w_txe_n_nxt    = r_tx_full;
          w_tx_state_nxt = TX_IDLE;
        end else begin
          w_tx_tmr_nxt = r_tx_tmr - 1'b1;
        end
      end
      default: w_tx_state_nxt = TX_IDLE;
    endcase
  end

  assign ft.rxf_n        = r_rxf_n;
  assign ft.txe_n        = r_txe_n;
  assign ft.d_oe         = r_d_oe;
  assign ft.d_out        = r_d_out;
  assign o_host_tx_ready = r_host_tx_ready;
  assign o_host_rx_data  = r_tx_mem[r_tx_rptr];
  assign o_host_rx_valid = ~r_tx_empty;
  assign o_proto_err     = r_proto_err;

endmodule

// File: tb/tb_ft245_responder.sv
// tb_ft245_responder
// Self-checking bench for ft245_responder (DEPTH_LOG2=4, RD_DELAY=1, TURN=2).
// Two queues hold the expected bytes. sb_rx holds host pushes in the order the
// master should read them, and sb_tx holds master writes in the order the host
// should drain them. Inputs are driven 1 ns after the rising edge, and outputs
// are sampled at that same point.
module tb_ft245_responder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] host_tx_data;
  logic       host_tx_valid;
  logic       host_tx_ready;
  logic [7:0] host_rx_data;
  logic       host_rx_valid;
  logic       host_rx_ready;
  logic       proto_err;

  ft245_responder_if ift ();

  ft245_responder #(.DEPTH_LOG2(4), .RD_DELAY(1), .TURN(2)) dut (
    .i_clock_in      (clk),
    .i_reset_n       (rst_n),
    .ft              (ift.slave),
    .i_host_tx_data  (host_tx_data),
    .i_host_tx_valid (host_tx_valid),
    .o_host_tx_ready (host_tx_ready),
    .o_host_rx_data  (host_rx_data),
    .o_host_rx_valid (host_rx_valid),
    .i_host_rx_ready (host_rx_ready),
    .o_proto_err     (proto_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] sb_rx[$];
  logic [7:0] sb_tx[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_push(input logic [7:0] b);
    int n = 0;
    host_tx_data  = b;
    host_tx_valid = 1'b1;
    while (!host_tx_ready && n < 200) begin tick(); n++; end
    chk("push_ready_wait", host_tx_ready, 1);
    sb_rx.push_back(b);
    tick();
    host_tx_valid = 1'b0;
  endtask

  task automatic host_pop();
    int n = 0;
    while (!host_rx_valid && n < 200) begin tick(); n++; end
    chk("pop_valid_wait", host_rx_valid, 1);
    chk("sb_tx_nonempty", sb_tx.size() != 0, 1);
    if (sb_tx.size() != 0) chk("host_rx_data", host_rx_data, sb_tx.pop_front());
    host_rx_ready = 1'b1;
    tick();
    host_rx_ready = 1'b0;
  endtask

  task automatic ft_read();
    int n = 0;
    while (ift.rxf_n && n < 200) begin tick(); n++; end
    chk("rd_rxf_wait", ift.rxf_n, 0);
    ift.rd_n = 1'b0;
    n = 0;
    while (!ift.d_oe && n < 50) begin tick(); n++; end
    chk("rd_doe_wait", ift.d_oe, 1);
    tick();
    chk("sb_rx_nonempty", sb_rx.size() != 0, 1);
    if (sb_rx.size() != 0) chk("rd_data", ift.d_out, sb_rx.pop_front());
    ift.rd_n = 1'b1;
    tick();
    chk("rd_end_doe", ift.d_oe, 0);
    chk("rd_end_rxf", ift.rxf_n, 1);
  endtask

  task automatic ft_write(input logic [7:0] b, input int low_cycles);
    int n = 0;
    while (ift.txe_n && n < 200) begin tick(); n++; end
    chk("wr_txe_wait", ift.txe_n, 0);
    ift.d_in = b;
    ift.wr_n = 1'b0;
    sb_tx.push_back(b);
    repeat (low_cycles) tick();
    ift.wr_n = 1'b1;
    tick();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n         = 1'b0;
    host_tx_data  = '0;
    host_tx_valid = 1'b0;
    host_rx_ready = 1'b0;
    ift.rd_n      = 1'b1;
    ift.wr_n      = 1'b1;
    ift.d_in      = '0;
    repeat (3) tick();
    chk("rst_rxf_n", ift.rxf_n, 1);
    chk("rst_txe_n", ift.txe_n, 1);
    chk("rst_d_oe", ift.d_oe, 0);
    chk("rst_d_out", ift.d_out, 0);
    chk("rst_proto_err", proto_err, 0);
    chk("rst_rx_valid", host_rx_valid, 0);
    chk("rst_tx_ready", host_tx_ready, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("rel_tx_ready", host_tx_ready, 1);
    chk("rel_txe_n", ift.txe_n, 0);
    chk("rel_rxf_n", ift.rxf_n, 1);

    // 1: single host byte read by the master, plus a push during the read
    host_push(8'hA5);
    chk("t1_rxf_lag", ift.rxf_n, 1);
    tick();
    chk("t1_rxf_fall", ift.rxf_n, 0);
    ift.rd_n = 1'b0;
    tick();
    chk("t1_doe_edge0", ift.d_oe, 0);
    tick();
    chk("t1_doe_edge1", ift.d_oe, 1);
    chk("t1_dout", ift.d_out, sb_rx.pop_front());
    host_push(8'h11);
    chk("t1_dout_stable_a", ift.d_out, 8'hA5);
    tick();
    chk("t1_dout_stable_b", ift.d_out, 8'hA5);
    chk("t1_doe_hold", ift.d_oe, 1);
    ift.rd_n = 1'b1;
    tick();
    chk("t1_pop_doe", ift.d_oe, 0);
    chk("t1_pre_rxf_a", ift.rxf_n, 1);
    tick();
    chk("t1_pre_rxf_b", ift.rxf_n, 1);
    tick();
    chk("t1_rxf_next", ift.rxf_n, 0);
    ft_read();
    repeat (4) tick();
    chk("t1_empty_rxf", ift.rxf_n, 1);

    // 2: long write pulse pushes exactly one byte
    ift.d_in = 8'h3C;
    ift.wr_n = 1'b0;
    sb_tx.push_back(8'h3C);
    tick();
    chk("t2_txe_busy", ift.txe_n, 1);
    chk("t2_rx_valid", host_rx_valid, 1);
    chk("t2_rx_data", host_rx_data, 8'h3C);
    ift.d_in = 8'hFF;
    tick();
    tick();
    ift.wr_n = 1'b1;
    tick();
    chk("t2_pre_txe_a", ift.txe_n, 1);
    tick();
    chk("t2_pre_txe_b", ift.txe_n, 1);
    tick();
    chk("t2_txe_free", ift.txe_n, 0);
    host_pop();
    chk("t2_single_push", host_rx_valid, 0);

    // 4: fill rx_fifo, then stream more while the master reads continuously
    for (int i = 0; i < 16; i++) host_push(8'(i));
    chk("t4_full_ready", host_tx_ready, 0);
    chk("t4_full_rxf", ift.rxf_n, 0);
    fork
      begin
        repeat (32) ft_read();
      end
      begin
        for (int i = 16; i < 32; i++) host_push(8'(i));
      end
    join
    chk("t4_sb_rx_drained", sb_rx.size(), 0);
    repeat (4) tick();
    chk("t4_rxf_empty", ift.rxf_n, 1);
    chk("t4_tx_ready", host_tx_ready, 1);

    // 5: overlapping read and write strobes
    host_push(8'h5A);
    fork
      ft_read();
      ft_write(8'hC3, 3);
    join
    host_pop();
    chk("t5_proto_err", proto_err, 0);

    // 3: fill tx_fifo, drop a 17th write, free one slot
    for (int i = 0; i < 16; i++) ft_write(8'(8'h80 + i), 1);
    repeat (4) tick();
    chk("t3_txe_full", ift.txe_n, 1);
    chk("t3_no_err_yet", proto_err, 0);
    ift.d_in = 8'hEE;
    ift.wr_n = 1'b0;
    tick();
    chk("t3_proto_err", proto_err, 1);
    ift.wr_n = 1'b1;
    tick();
    host_pop();
    tick();
    chk("t3_txe_after_pop", ift.txe_n, 0);
    for (int i = 0; i < 15; i++) host_pop();
    chk("t3_drained", host_rx_valid, 0);
    chk("t3_err_sticky", proto_err, 1);

    // 6: reset while the responder is driving read data
    ft_write(8'h44, 1);
    host_push(8'h77);
    n = 0;
    while (ift.rxf_n && n < 50) begin tick(); n++; end
    chk("t6_rxf_wait", ift.rxf_n, 0);
    ift.rd_n = 1'b0;
    n = 0;
    while (!ift.d_oe && n < 50) begin tick(); n++; end
    chk("t6_doe_up", ift.d_oe, 1);
    chk("t6_rx_valid_pre", host_rx_valid, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_doe_async", ift.d_oe, 0);
    chk("t6_rxf_n", ift.rxf_n, 1);
    chk("t6_txe_n", ift.txe_n, 1);
    chk("t6_tx_ready", host_tx_ready, 0);
    chk("t6_rx_valid", host_rx_valid, 0);
    chk("t6_proto_err", proto_err, 0);
    chk("t6_d_out", ift.d_out, 0);
    sb_rx.delete();
    sb_tx.delete();
    ift.rd_n = 1'b1;
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("t6_rel_tx_ready", host_tx_ready, 1);
    chk("t6_rel_txe_n", ift.txe_n, 0);
    tick();
    chk("t6_rel_rxf_n", ift.rxf_n, 1);
    chk("t6_rel_rx_valid", host_rx_valid, 0);

    chk("sb_tx_drained", sb_tx.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
